// File: rtl/lane_mem_arbiter_pkg.sv
// Shared defaults, source-width derivation and request record for the lane memory arbiter.
package lane_mem_arbiter_pkg;

  localparam int unsigned DefNumLanes    = 4;
  localparam int unsigned DefDataWidth   = 64;
  localparam int unsigned DefLogsizeWidth = 3;
  localparam int unsigned DefMaxInflight = 4;

  function automatic int unsigned src_w(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  localparam int unsigned DefSrcW = (DefNumLanes > 1) ? $clog2(DefNumLanes) : 1;

  typedef struct packed {
    logic [DefDataWidth-1:0]    address;
    logic                       is_store;
    logic [DefLogsizeWidth-1:0] size;
    logic [DefDataWidth-1:0]    data;
    logic [DefSrcW-1:0]         source;
  } mem_req_t;

endpackage

// File: rtl/lane_mem_arbiter_if.sv
// Lane-side and memory-side channels plus status of the lane memory arbiter.
interface lane_mem_arbiter_if
  import lane_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_LANES     = DefNumLanes,
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned LOGSIZE_WIDTH = DefLogsizeWidth
) ();

  localparam int unsigned SRC_W = src_w(NUM_LANES);

  logic [NUM_LANES-1:0]               lane_a_valid;
  logic [NUM_LANES-1:0]               lane_a_ready;
  logic [DATA_WIDTH*NUM_LANES-1:0]    lane_a_address;
  logic [NUM_LANES-1:0]               lane_a_is_store;
  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] lane_a_size;
  logic [DATA_WIDTH*NUM_LANES-1:0]    lane_a_data;

  logic [NUM_LANES-1:0]               lane_d_valid;
  logic [NUM_LANES-1:0]               lane_d_ready;
  logic [DATA_WIDTH-1:0]              lane_d_data;
  logic                               lane_d_is_store;

  logic                               mem_a_valid;
  logic                               mem_a_ready;
  logic [DATA_WIDTH-1:0]              mem_a_address;
  logic                               mem_a_is_store;
  logic [LOGSIZE_WIDTH-1:0]           mem_a_size;
  logic [DATA_WIDTH-1:0]              mem_a_data;
  logic [SRC_W-1:0]                   mem_a_source;

  logic                               mem_d_valid;
  logic                               mem_d_ready;
  logic [SRC_W-1:0]                   mem_d_source;
  logic [DATA_WIDTH-1:0]              mem_d_data;
  logic                               mem_d_is_store;

  logic                               idle;
  logic                               src_error;

  // Arbiter view: accepts lane requests, masters the memory port.
  modport master (
    input  lane_a_valid, lane_a_address, lane_a_is_store, lane_a_size, lane_a_data,
    output lane_a_ready,
    output lane_d_valid, lane_d_data, lane_d_is_store,
    input  lane_d_ready,
    output mem_a_valid, mem_a_address, mem_a_is_store, mem_a_size, mem_a_data, mem_a_source,
    input  mem_a_ready,
    input  mem_d_valid, mem_d_source, mem_d_data, mem_d_is_store,
    output mem_d_ready,
    output idle, src_error
  );

  modport slave (
    output lane_a_valid, lane_a_address, lane_a_is_store, lane_a_size, lane_a_data,
    input  lane_a_ready,
    input  lane_d_valid, lane_d_data, lane_d_is_store,
    output lane_d_ready,
    input  mem_a_valid, mem_a_address, mem_a_is_store, mem_a_size, mem_a_data, mem_a_source,
    output mem_a_ready,
    output mem_d_valid, mem_d_source, mem_d_data, mem_d_is_store,
    input  mem_d_ready,
    input  idle, src_error
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or above the priority pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_mem_arbiter.sv
// Multi-lane to single memory port arbiter with per-lane outstanding limits and
// combinational response routing by source id.
module lane_mem_arbiter
  import lane_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_LANES     = DefNumLanes,
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned LOGSIZE_WIDTH = DefLogsizeWidth,
  parameter int unsigned MAX_INFLIGHT  = DefMaxInflight
) (
  input logic                clock,
  input logic                reset_n,
  lane_mem_arbiter_if.master bus
);

  localparam int unsigned SRC_W = src_w(NUM_LANES);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_INFLIGHT);
  localparam logic [SRC_W-1:0] LastLane = SRC_W'(NUM_LANES - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    address;
    logic                     is_store;
    logic [LOGSIZE_WIDTH-1:0] size;
    logic [DATA_WIDTH-1:0]    data;
    logic [SRC_W-1:0]         source;
  } req_t;

  req_t                 r_stage;
  logic                 r_stage_valid;
  logic [SRC_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_inflight [NUM_LANES];
  logic                 r_src_error;

  req_t                 w_sel;
  logic [SRC_W-1:0]     w_gidx;
  logic [NUM_LANES-1:0] w_elig, w_grant, w_a_fire;
  logic [NUM_LANES-1:0] w_busy, w_src_hit, w_d_valid, w_d_fire;
  logic                 w_can_accept, w_d_bad;

  always_comb begin
    w_elig    = '0;
    w_busy    = '0;
    w_src_hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_elig[i]    = bus.lane_a_valid[i] && (r_inflight[i] < MaxCnt);
      w_busy[i]    = (r_inflight[i] != '0);
      w_src_hit[i] = (bus.mem_d_source == SRC_W'(i));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_LANES),
    .PTR_W   (SRC_W)
  ) u_rr_arbiter (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // The stage can take a new request if it is empty or draining this cycle.
  assign w_can_accept     = reset_n && (!r_stage_valid || bus.mem_a_ready);
  assign w_a_fire         = w_can_accept ? w_grant : '0;
  assign bus.lane_a_ready = w_a_fire;

  always_comb begin
    w_gidx = '0;
    w_sel  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_grant[i]) begin
        w_gidx         = SRC_W'(i);
        w_sel.address  = bus.lane_a_address[DATA_WIDTH*i +: DATA_WIDTH];
        w_sel.is_store = bus.lane_a_is_store[i];
        w_sel.size     = bus.lane_a_size[LOGSIZE_WIDTH*i +: LOGSIZE_WIDTH];
        w_sel.data     = bus.lane_a_data[DATA_WIDTH*i +: DATA_WIDTH];
        w_sel.source   = SRC_W'(i);
      end
    end
  end

  // Responses to an unknown or idle lane are swallowed and flagged.
  assign w_d_valid = (reset_n && bus.mem_d_valid) ? (w_src_hit & w_busy) : '0;
  assign w_d_bad   = bus.mem_d_valid && !(|(w_src_hit & w_busy));
  assign w_d_fire  = w_d_valid & bus.lane_d_ready;

  assign bus.lane_d_valid    = w_d_valid;
  assign bus.lane_d_data     = bus.mem_d_data;
  assign bus.lane_d_is_store = bus.mem_d_is_store;
  assign bus.mem_d_ready     = reset_n && (w_d_bad || |(w_src_hit & bus.lane_d_ready));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stage       <= '0;
      r_stage_valid <= 1'b0;
      r_ptr         <= '0;
      r_src_error   <= 1'b0;
    end else begin
      if (|w_a_fire) begin
        r_stage       <= w_sel;
        r_stage_valid <= 1'b1;
        r_ptr         <= (w_gidx == LastLane) ? '0 : w_gidx + 1'b1;
      end else if (bus.mem_a_ready) begin
        r_stage_valid <= 1'b0;
      end
      if (w_d_bad) begin
        r_src_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!reset_n) begin
        r_inflight[i] <= '0;
      end else if (w_a_fire[i] && !w_d_fire[i]) begin
        r_inflight[i] <= r_inflight[i] + 1'b1;
      end else if (w_d_fire[i] && !w_a_fire[i]) begin
        r_inflight[i] <= r_inflight[i] - 1'b1;
      end
    end
  end

  assign bus.mem_a_valid    = r_stage_valid;
  assign bus.mem_a_address  = r_stage.address;
  assign bus.mem_a_is_store = r_stage.is_store;
  assign bus.mem_a_size     = r_stage.size;
  assign bus.mem_a_data     = r_stage.data;
  assign bus.mem_a_source   = r_stage.source;
  assign bus.idle           = !r_stage_valid && !(|w_busy);
  assign bus.src_error      = r_src_error;

endmodule

// File: tb/tb_lane_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_lane_mem_arbiter;
  import lane_mem_arbiter_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 3;
  localparam int unsigned MI = 4;
  localparam int unsigned SW = src_w(NL);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lane_mem_arbiter_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW)) bus ();

  lane_mem_arbiter #(
    .NUM_LANES     (NL),
    .DATA_WIDTH    (DW),
    .LOGSIZE_WIDTH (LW),
    .MAX_INFLIGHT  (MI)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    bus.lane_a_valid    = '0;
    bus.lane_a_address  = '0;
    bus.lane_a_is_store = '0;
    bus.lane_a_size     = '0;
    bus.lane_a_data     = '0;
    bus.lane_d_ready    = '0;
    bus.mem_a_ready     = 1'b1;
    bus.mem_d_valid     = 1'b0;
    bus.mem_d_source    = '0;
    bus.mem_d_data      = '0;
    bus.mem_d_is_store  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Reference model state for the randomized run.
  int              m_inf [NL];
  int              m_ptr;
  bit              m_v;
  logic [63:0]     m_addr, m_data;
  logic [2:0]      m_size;
  logic            m_st;
  int              m_src;
  logic [63:0]     ra [NL];
  logic [63:0]     rd [NL];
  logic [2:0]      rs [NL];
  logic [NL-1:0]   rst;

  initial begin
    quiet_inputs();

    // Reset behaviour with all lanes requesting and a response offered.
    for (int i = 0; i < NL; i++) bus.lane_a_address[DW*i +: DW] = 64'h100 + 64'(i);
    bus.lane_a_valid = 4'hF;
    bus.mem_d_valid  = 1'b1;
    bus.lane_d_ready = 4'hF;
    reset_n = 1'b0;
    tick();
    settle();
    chk("rst_lane_a_ready", 64'(bus.lane_a_ready), 64'h0);
    chk("rst_mem_d_ready", 64'(bus.mem_d_ready), 64'h0);
    chk("rst_lane_d_valid", 64'(bus.lane_d_valid), 64'h0);
    bus.mem_d_valid = 1'b0;
    tick();
    chk("rst_mem_a_valid", 64'(bus.mem_a_valid), 64'h0);
    chk("rst_mem_a_address", bus.mem_a_address, 64'h0);
    chk("rst_idle", 64'(bus.idle), 64'h1);
    chk("rst_src_error", 64'(bus.src_error), 64'h0);

    // Round-robin over four always-valid lanes, one grant per cycle.
    reset_n = 1'b1;
    settle();
    chk("rr_first_ready", 64'(bus.lane_a_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_mem_a_valid", 64'(bus.mem_a_valid), 64'h1);
      chk("rr_mem_a_source", 64'(bus.mem_a_source), 64'(k % 4));
      chk("rr_mem_a_address", bus.mem_a_address, 64'h100 + 64'(k % 4));
    end

    // Reset with requests outstanding; pointer back at 0 picks lane 0 over lane 3.
    bus.lane_a_valid = 4'b1001;
    reset_n = 1'b0;
    settle();
    chk("midrst_lane_a_ready", 64'(bus.lane_a_ready), 64'h0);
    tick();
    chk("midrst_idle", 64'(bus.idle), 64'h1);
    chk("midrst_mem_a_valid", 64'(bus.mem_a_valid), 64'h0);
    reset_n = 1'b1;
    settle();
    chk("midrst_ptr_zero", 64'(bus.lane_a_ready), 64'h1);
    bus.lane_a_valid = '0;

    // Late response to a lane with nothing in flight.
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = SW'(0);
    bus.lane_d_ready = 4'hF;
    settle();
    chk("late_mem_d_ready", 64'(bus.mem_d_ready), 64'h1);
    chk("late_lane_d_valid", 64'(bus.lane_d_valid), 64'h0);
    tick();
    bus.mem_d_valid = 1'b0;
    settle();
    chk("late_src_error", 64'(bus.src_error), 64'h1);

    // Source 5 fits the source field only as its low bits (lane 1, which is idle).
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = SW'(5);
    settle();
    chk("bad_src_mem_d_ready", 64'(bus.mem_d_ready), 64'h1);
    chk("bad_src_lane_d_valid", 64'(bus.lane_d_valid), 64'h0);
    tick();
    bus.mem_d_valid = 1'b0;
    tick();
    chk("bad_src_sticky", 64'(bus.src_error), 64'h1);
    do_reset();
    chk("bad_src_cleared", 64'(bus.src_error), 64'h0);

    // Back-pressure: lane 2 at 0x1000 held while memory stalls.
    bus.lane_a_address[DW*2 +: DW] = 64'h1000;
    bus.lane_a_valid = 4'b0100;
    bus.mem_a_ready  = 1'b0;
    settle();
    chk("stall_first_ready", 64'(bus.lane_a_ready), 64'h4);
    tick();
    bus.lane_a_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_no_ready", 64'(bus.lane_a_ready), 64'h0);
      chk("stall_mem_a_valid", 64'(bus.mem_a_valid), 64'h1);
      chk("stall_mem_a_address", bus.mem_a_address, 64'h1000);
      chk("stall_mem_a_source", 64'(bus.mem_a_source), 64'h2);
      tick();
    end
    bus.mem_a_ready = 1'b1;
    settle();
    chk("stall_release_ready", 64'(bus.lane_a_ready), 64'h1);
    bus.lane_a_valid = '0;
    do_reset();

    // Lane 1 saturates at the outstanding limit while lane 3 still wins.
    bus.lane_a_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("sat_l1_ready", 64'(bus.lane_a_ready), 64'h2);
      tick();
    end
    bus.lane_a_valid = 4'b1010;
    settle();
    chk("sat_l3_granted", 64'(bus.lane_a_ready), 64'h8);
    tick();
    bus.lane_a_valid = 4'b0010;
    settle();
    chk("sat_l1_blocked", 64'(bus.lane_a_ready), 64'h0);
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = SW'(1);
    bus.lane_d_ready = 4'b0010;
    settle();
    chk("sat_resp_lane_d_valid", 64'(bus.lane_d_valid), 64'h2);
    chk("sat_resp_mem_d_ready", 64'(bus.mem_d_ready), 64'h1);
    tick();
    bus.mem_d_valid = 1'b0;
    settle();
    chk("sat_l1_reeligible", 64'(bus.lane_a_ready), 64'h2);
    bus.lane_a_valid = '0;
    do_reset();

    // Lane 0: stalled response keeps the count; same-cycle accept+complete keeps it too.
    bus.lane_a_valid = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = SW'(0);
    bus.lane_d_ready = 4'b0000;
    settle();
    chk("d_stall_mem_d_ready", 64'(bus.mem_d_ready), 64'h0);
    chk("d_stall_lane_d_valid", 64'(bus.lane_d_valid), 64'h1);
    tick();
    chk("d_stall_count_kept", 64'(bus.lane_a_ready), 64'h0);
    bus.lane_d_ready = 4'b0001;
    settle();
    chk("d_done_mem_d_ready", 64'(bus.mem_d_ready), 64'h1);
    tick();
    chk("same_cycle_ready", 64'(bus.lane_a_ready), 64'h1);
    tick();
    bus.mem_d_valid = 1'b0;
    settle();
    chk("after_same_cycle_ready", 64'(bus.lane_a_ready), 64'h1);
    tick();
    chk("back_at_limit", 64'(bus.lane_a_ready), 64'h0);
    bus.lane_a_valid = '0;
    quiet_inputs();
    do_reset();

    // Randomized run against the model.
    for (int i = 0; i < NL; i++) m_inf[i] = 0;
    m_ptr = 0;
    m_v   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [NL-1:0] lv, ldr;
      bit            dv, acc, dfire, all_zero;
      int            r, g;
      logic [NL-1:0] exp_ready;
      lv = NL'($urandom_range(0, 15));
      ldr = NL'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) begin
        ra[i]  = {$urandom, $urandom};
        rd[i]  = {$urandom, $urandom};
        rs[i]  = 3'($urandom_range(0, 7));
        rst[i] = 1'($urandom_range(0, 1));
        bus.lane_a_address[DW*i +: DW] = ra[i];
        bus.lane_a_data[DW*i +: DW]    = rd[i];
        bus.lane_a_size[LW*i +: LW]    = rs[i];
      end
      bus.lane_a_is_store = rst;
      bus.lane_a_valid    = lv;
      bus.lane_d_ready    = ldr;
      bus.mem_a_ready     = ($urandom_range(0, 3) != 0);
      r  = int'($urandom_range(0, NL - 1));
      dv = (m_inf[r] > 0) && ($urandom_range(0, 1) == 1);
      bus.mem_d_valid    = dv;
      bus.mem_d_source   = SW'(r);
      bus.mem_d_data     = {$urandom, $urandom};
      bus.mem_d_is_store = 1'($urandom_range(0, 1));
      settle();

      g = -1;
      for (int k = 0; k < NL; k++) begin
        int idx;
        idx = (m_ptr + k) % NL;
        if (g < 0 && lv[idx] && m_inf[idx] < MI) g = idx;
      end
      acc = (g >= 0) && (!m_v || bus.mem_a_ready);
      exp_ready = acc ? NL'(1 << g) : '0;
      chk("rnd_lane_a_ready", 64'(bus.lane_a_ready), 64'(exp_ready));
      chk("rnd_mem_a_valid", 64'(bus.mem_a_valid), 64'(m_v));
      if (m_v) begin
        chk("rnd_mem_a_address", bus.mem_a_address, m_addr);
        chk("rnd_mem_a_data", bus.mem_a_data, m_data);
        chk("rnd_mem_a_size", 64'(bus.mem_a_size), 64'(m_size));
        chk("rnd_mem_a_is_store", 64'(bus.mem_a_is_store), 64'(m_st));
        chk("rnd_mem_a_source", 64'(bus.mem_a_source), 64'(m_src));
      end
      if (dv) begin
        chk("rnd_lane_d_valid", 64'(bus.lane_d_valid), 64'(1 << r));
        chk("rnd_mem_d_ready", 64'(bus.mem_d_ready), 64'(ldr[r]));
        chk("rnd_lane_d_data", bus.lane_d_data, bus.mem_d_data);
      end else begin
        chk("rnd_no_lane_d_valid", 64'(bus.lane_d_valid), 64'h0);
      end
      all_zero = 1'b1;
      for (int i = 0; i < NL; i++) if (m_inf[i] != 0) all_zero = 1'b0;
      chk("rnd_idle", 64'(bus.idle), 64'(all_zero && !m_v));
      chk("rnd_src_error", 64'(bus.src_error), 64'h0);

      dfire = dv && ldr[r];
      if (acc) begin
        m_v    = 1'b1;
        m_addr = ra[g];
        m_data = rd[g];
        m_size = rs[g];
        m_st   = rst[g];
        m_src  = g;
        m_inf[g]++;
        m_ptr = (g + 1) % NL;
      end else if (bus.mem_a_ready) begin
        m_v = 1'b0;
      end
      if (dfire) m_inf[r]--;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
